// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: weight preload, skewed ifmap feed, psum-valid flags.
// state  | meaning
// IDLE   | waiting for start, all strobes low
// LOAD_W | shifting weights down the columns, bottom row first
// FEED   | streaming skewed ifmap vectors with Run high
// DONE   | one-cycle completion pulse
module systolic_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int TW   = LEN_W + 1
) (
  input  logic             iClk,
  input  logic             iRest_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_keep_w,
  output logic             enable_w,
  output logic             w_rd_en,
  output logic [RW-1:0]    w_row,
  output logic             Run,
  output logic [TW-1:0]    t_cnt,
  output logic [ROWS-1:0]  row_valid,
  output logic [COLS-1:0]  col_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_FEED   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    w_row_d;
  logic [TW-1:0]    t_d, t_last;
  logic [LEN_W-1:0] n_q, n_d;
  logic [ROWS-1:0]  row_valid_d;
  logic [COLS-1:0]  col_valid_d;

  always_comb begin
    state_d = state_q;
    w_row_d = '0;
    t_d     = '0;
    n_d     = n_q;
    t_last  = {1'b0, n_q} + TW'(ROWS + COLS - 2);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d = cfg_len;
          if (cfg_len == '0) begin
            state_d = S_DONE;
          end else if (cfg_keep_w) begin
            state_d = S_FEED;
          end else begin
            state_d = S_LOAD_W;
            w_row_d = RW'(ROWS - 1);
          end
        end
      end
      S_LOAD_W: begin
        if (w_row == '0) state_d = S_FEED;
        else             w_row_d = w_row - RW'(1);
      end
      S_FEED: begin
        if (t_cnt == t_last) state_d = S_DONE;
        else                 t_d = t_cnt + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      w_row_d = '0;
      t_d     = '0;
      n_d     = n_q;
    end
    // Row r carries vector t-r; column c emits vector t-ROWS-c, both valid for N vectors.
    for (int r = 0; r < ROWS; r++) begin
      row_valid_d[r] = (state_d == S_FEED) && (t_d >= TW'(r)) &&
                       ({1'b0, t_d} < ({2'b00, n_d} + (TW+1)'(r)));
    end
    for (int c = 0; c < COLS; c++) begin
      col_valid_d[c] = (state_d == S_FEED) && (t_d >= TW'(ROWS + c)) &&
                       ({1'b0, t_d} < ({2'b00, n_d} + (TW+1)'(ROWS + c)));
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRest_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      enable_w  <= 1'b0;
      w_rd_en   <= 1'b0;
      w_row     <= '0;
      Run       <= 1'b0;
      t_cnt     <= '0;
      row_valid <= '0;
      col_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      enable_w  <= (state_d == S_LOAD_W);
      w_rd_en   <= (state_d == S_LOAD_W);
      w_row     <= w_row_d;
      Run       <= (state_d == S_FEED);
      t_cnt     <= t_d;
      row_valid <= row_valid_d;
      col_valid <= col_valid_d;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: directed scenarios plus random traffic against a cycle-offset reference model.
module tb_systolic_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 8;

  logic             iClk = 1'b0;
  logic             iRest_n;
  logic             start, abort, cfg_keep_w;
  logic [LEN_W-1:0] cfg_len;
  logic             enable_w, w_rd_en, Run, busy, done;
  logic [1:0]       w_row;
  logic [LEN_W:0]   t_cnt;
  logic [ROWS-1:0]  row_valid;
  logic [COLS-1:0]  col_valid;

  int checks   = 0;
  int failures = 0;

  // Model: active flag plus k = cycles elapsed since the accepting edge.
  bit m_act  = 0;
  int m_k    = 0;
  int m_n    = 0;
  bit m_keep = 0;
  int max_t  = 0;

  always #5 iClk = ~iClk;

  systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .iClk(iClk), .iRest_n(iRest_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_keep_w(cfg_keep_w),
    .enable_w(enable_w), .w_rd_en(w_rd_en), .w_row(w_row), .Run(Run),
    .t_cnt(t_cnt), .row_valid(row_valid), .col_valid(col_valid),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (time %0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int total_cycles(int n, bit keep);
    if (n == 0) return 1;
    return (keep ? 0 : ROWS) + (n + ROWS + COLS - 1) + 1;
  endfunction

  task automatic step(input bit s, input bit a, input bit rst, input int len, input bit kw);
    int lw, tt, et, ew;
    bit een, erun, ebusy, edone;
    logic [ROWS-1:0] erv;
    logic [COLS-1:0] ecv;
    @(negedge iClk);
    start = s; abort = a; iRest_n = !rst; cfg_len = LEN_W'(len); cfg_keep_w = kw;
    if (rst || a) m_act = 0;
    else if (!m_act) begin
      if (s) begin m_act = 1; m_k = 1; m_n = len; m_keep = kw; end
    end else begin
      m_k++;
      if (m_k > total_cycles(m_n, m_keep)) m_act = 0;
    end
    een = 0; erun = 0; ebusy = 0; edone = 0; et = 0; ew = 0; erv = '0; ecv = '0;
    if (m_act) begin
      ebusy = 1;
      lw = m_keep ? 0 : ROWS;
      tt = m_n + ROWS + COLS - 1;
      if (m_n == 0) edone = 1;
      else if (m_k <= lw) begin een = 1; ew = ROWS - m_k; end
      else if (m_k <= lw + tt) begin
        erun = 1; et = m_k - lw - 1;
        for (int r = 0; r < ROWS; r++) erv[r] = (et >= r) && (et <= m_n - 1 + r);
        for (int c = 0; c < COLS; c++) ecv[c] = (et >= ROWS + c) && (et <= m_n - 1 + ROWS + c);
      end else edone = 1;
    end
    @(posedge iClk); #1;
    check("enable_w", 32'(enable_w), 32'(een));
    check("w_rd_en", 32'(w_rd_en), 32'(een));
    check("w_row", 32'(w_row), 32'(ew));
    check("run", 32'(Run), 32'(erun));
    check("t_cnt", 32'(t_cnt), 32'(et));
    check("row_valid", 32'(row_valid), 32'(erv));
    check("col_valid", 32'(col_valid), 32'(ecv));
    check("busy", 32'(busy), 32'(ebusy));
    check("done", 32'(done), 32'(edone));
    check("en_run_excl", 32'(enable_w & Run), 32'(0));
    if (Run && int'(t_cnt) > max_t) max_t = int'(t_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    iRest_n = 0; start = 0; abort = 0; cfg_len = '0; cfg_keep_w = 0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    // basic run, weight reuse, empty run
    step(1, 0, 0, 3, 0); idle(17);
    step(1, 0, 0, 2, 1); idle(12);
    step(1, 0, 0, 0, 0); idle(3);
    // abort during FEED at t=3, then a full run
    step(1, 0, 0, 3, 0); idle(7);
    check("abort_at_t3", 32'(t_cnt), 32'(3));
    step(0, 1, 0, 0, 0); idle(2);
    step(1, 0, 0, 3, 0); idle(17);
    // reset while w_row=2
    step(1, 0, 0, 5, 0); idle(1);
    check("rst_at_wrow2", 32'(w_row), 32'(2));
    step(0, 0, 1, 0, 0); idle(2);
    // start and cfg change mid-run ignored, then back-to-back start in IDLE cycle
    step(1, 0, 0, 4, 0); idle(6);
    step(1, 0, 0, 9, 0); idle(4);
    step(1, 0, 0, 200, 1); idle(3);
    check("b2b_done", 32'(done), 32'(1));
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 2, 0); idle(16);
    // start with abort in IDLE
    step(1, 1, 0, 5, 0); idle(2);
    // maximum length
    max_t = 0;
    step(1, 0, 0, 255, 0); idle(270);
    check("max_t_cnt", 32'(max_t), 32'(261));
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int len;
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 299) == 0, len, $urandom_range(0, 1) == 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
